// File: rtl/mult_share_arb.sv
// Two-requester arbiter time-sharing one unsigned shift-add multiplier (WIDTH shift cycles per job).
// Define MULT_SHARE_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module mult_share_arb #(
  parameter int WIDTH = 4
) (
  input  logic               mHz,
  input  logic               reset,
  input  logic               start0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               busy0,
  output logic               done0,
  output logic [2*WIDTH-1:0] result0,
  input  logic               start1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               busy1,
  output logic               done1,
  output logic [2*WIDTH-1:0] result1
);

  localparam int PW = 2 * WIDTH;
  localparam int NW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic              pending0, pending1;
  logic [WIDTH-1:0]  op_a0, op_b0, op_a1, op_b1;
  logic              sel;
  logic              winner;
  logic [PW-1:0]     acc, mcand, acc_sum;
  logic [WIDTH-1:0]  mplier;
  logic [NW-1:0]     n;
  logic              last;
`ifndef MULT_SHARE_FIXED_PRIO_EN
  logic              rr_ptr;
`endif

  assign busy0 = pending0;
  assign busy1 = pending1;

  always_comb begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
    winner = ~pending0;
`else
    if (pending0 && pending1) winner = rr_ptr;
    else                      winner = ~pending0;
`endif
  end

  // Product for the final shift step is taken from this sum, not the registered acc.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;
  assign last    = (n == NW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending0 || pending1) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mHz) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge mHz) begin
    if (!reset) begin
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      op_a0    <= '0;
      op_b0    <= '0;
      op_a1    <= '0;
      op_b1    <= '0;
      sel      <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      n        <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result0  <= '0;
      result1  <= '0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      if (start0 && !pending0) begin
        op_a0    <= a0;
        op_b0    <= b0;
        pending0 <= 1'b1;
      end
      if (start1 && !pending1) begin
        op_a1    <= a1;
        op_b1    <= b1;
        pending1 <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pending0 || pending1) begin
            sel    <= winner;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, (winner ? op_a1 : op_a0)};
            mplier <= winner ? op_b1 : op_b0;
            n      <= NW'(WIDTH);
          end
        end
        SHIFT: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          n      <= n - NW'(1);
          if (last) begin
            if (sel) begin
              result1 <= acc_sum;
              done1   <= 1'b1;
            end else begin
              result0 <= acc_sum;
              done0   <= 1'b1;
            end
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          // Clearing here overrides a same-edge capture, since the slot was still busy.
          if (sel) pending1 <= 1'b0;
          else     pending0 <= 1'b0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
          rr_ptr <= ~sel;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: stimulus pushes expected (requester, product, done edge),
// a negedge monitor pops on every done pulse and also tracks held result values.
module tb_mult_share_arb;
  localparam int WIDTH = 4;

  logic       mHz = 1'b0;
  logic       reset = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       busy0, busy1, done0, done1;
  logic [7:0] result0, result1;

  mult_share_arb #(.WIDTH(WIDTH)) dut (
    .mHz(mHz), .reset(reset),
    .start0(start0), .a0(a0), .b0(b0), .busy0(busy0), .done0(done0), .result0(result0),
    .start1(start1), .a1(a1), .b1(b1), .busy1(busy1), .done1(done1), .result1(result1)
  );

  always #5 mHz = ~mHz;

  int cyc = 0;
  always @(posedge mHz) cyc <= cyc + 1;

  typedef struct {
    bit         req;
    logic [7:0] val;
    int         edge_n;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] mdl_r0 = '0, mdl_r1 = '0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: runs just after each negedge so stimulus updates at the same negedge are visible.
  always @(negedge mHz) begin
    exp_t e;
    #1;
    check("done_exclusive", int'(done0 & done1), 0);
    if (done0 || done1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("done_req", int'(done1), int'(e.req));
        check("done_edge", cyc, e.edge_n);
        if (e.req) mdl_r1 = e.val;
        else       mdl_r0 = e.val;
      end
    end
    check("result0", int'(result0), int'(mdl_r0));
    check("result1", int'(result1), int'(mdl_r1));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge mHz);
  endtask

  // Drives one start edge; e returns the edge number at which the inputs are sampled.
  task automatic go(input bit s0, input int av0, input int bv0,
                    input bit s1, input int av1, input int bv1, output int e);
    @(negedge mHz);
    start0 = s0; a0 = 4'(av0); b0 = 4'(bv0);
    start1 = s1; a1 = 4'(av1); b1 = 4'(bv1);
    e = cyc + 1;
    @(negedge mHz);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mHz);
    reset = 1'b0;
    @(negedge mHz);
    mdl_r0 = '0;
    mdl_r1 = '0;
    q.delete();
    reset = 1'b1;
  endtask

  initial begin
    int e;
    repeat (2) @(posedge mHz);
    @(negedge mHz);
    check("rst_busy0", int'(busy0), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_done1", int'(done1), 0);
    reset = 1'b1;

    // 1: single job 3*5, done exactly one cycle after edge e+5, busy drops after e+6
    go(1, 3, 5, 0, 0, 0, e);
    q.push_back('{1'b0, 8'd15, e + 5});
    idle(5);
    check("busy0_at_done", int'(busy0), 1);
    idle(1);
    check("busy0_after", int'(busy0), 0);
    idle(2);

    // 2: max operands on requester 1
    go(0, 0, 0, 1, 15, 15, e);
    q.push_back('{1'b1, 8'hE1, e + 5});
    idle(8);

    // 3: simultaneous starts after reset
    do_reset();
    go(1, 2, 7, 1, 9, 9, e);
    q.push_back('{1'b0, 8'd14, e + 5});
    q.push_back('{1'b1, 8'd81, e + 11});
    idle(13);
    // lone requester-0 job leaves requester 1 with priority for the next collision
    go(1, 1, 1, 0, 0, 0, e);
    q.push_back('{1'b0, 8'd1, e + 5});
    idle(8);
    go(1, 5, 3, 1, 6, 7, e);
`ifdef MULT_SHARE_FIXED_PRIO_EN
    q.push_back('{1'b0, 8'd15, e + 5});
    q.push_back('{1'b1, 8'd42, e + 11});
`else
    q.push_back('{1'b1, 8'd42, e + 5});
    q.push_back('{1'b0, 8'd15, e + 11});
`endif
    idle(13);

    // 4: second start while busy is ignored
    go(1, 4, 4, 0, 0, 0, e);
    q.push_back('{1'b0, 8'd16, e + 5});
    idle(1);
    go(1, 7, 7, 0, 0, 0, e);
    idle(10);

    // 5: reset mid-operation aborts the job
    go(1, 6, 6, 0, 0, 0, e);
    idle(2);
    reset = 1'b0;
    @(negedge mHz);
    mdl_r0 = '0;
    mdl_r1 = '0;
    q.delete();
    check("abort_busy0", int'(busy0), 0);
    check("abort_result0", int'(result0), 0);
    check("abort_done0", int'(done0), 0);
    reset = 1'b1;
    idle(10);
    go(1, 6, 6, 0, 0, 0, e);
    q.push_back('{1'b0, 8'd36, e + 5});
    idle(8);

    // 6: zero multiplier still takes the full sequence
    go(1, 13, 0, 0, 0, 0, e);
    q.push_back('{1'b0, 8'd0, e + 5});
    idle(8);

    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
